// File: rtl/data_memory_arbiter.sv
// Purpose: shares one 2048x64 single-port data RAM between two requesters with round-robin grant, range/alignment check, byte steering and load extension.
// Latency: grant in cycle T -> rvalid at T+1 (illegal), T+2 (store), T+3 (load); one transaction outstanding at a time.
// Backpressure: requests are held until a one-cycle gnt; grants are only issued in IDLE, so other requests wait out the current transaction.
module data_memory_arbiter #(
    parameter logic [31:0] DATA_BEGIN = 32'h0001_0000,
    parameter logic [31:0] DATA_END   = 32'h0001_3FFF
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [2:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [63:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [63:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [2:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [63:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [63:0] m1_rdata,
    output logic        m1_err,

    output logic [10:0] ram_address,
    output logic [7:0]  ram_byteena,
    output logic [63:0] ram_data,
    output logic        ram_rden,
    output logic        ram_wren,
    input  logic [63:0] ram_q
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    // Latched operation; only the in-window address bits are kept since the
    // range check is resolved at grant time.
    typedef struct packed {
        logic        port;
        logic        we;
        logic [2:0]  size;
        logic [13:0] addr;
        logic [63:0] wdata;
        logic        legal;
    } op_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;
    op_t         op_q;

    logic        grant_vld;
    logic        grant_port;
    op_t         req_op;
    logic        resp_port;
    logic        resp_err;
    logic [63:0] resp_data;
    logic [63:0] shifted_q;
    logic [63:0] load_result;
    logic [7:0]  be_base;

    // Address must fall in the data window and be naturally aligned to the access size.
    function automatic logic addr_legal(input logic [31:0] a, input logic [2:0] s);
        logic aligned;
        case (s[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~a[0];
            2'b10:   aligned = (a[1:0] == 2'b00);
            default: aligned = (a[2:0] == 3'b000);
        endcase
        return (a >= DATA_BEGIN) && (a <= DATA_END) && aligned;
    endfunction

    // Round-robin pick among active requests; only while idle and out of reset.
    always_comb begin
        grant_vld  = 1'b0;
        grant_port = 1'b0;
        if (state == S_IDLE && reset_n) begin
            if (m0_req && m1_req) begin
                grant_vld  = 1'b1;
                grant_port = ~last_grant;
            end else if (m0_req) begin
                grant_vld  = 1'b1;
                grant_port = 1'b0;
            end else if (m1_req) begin
                grant_vld  = 1'b1;
                grant_port = 1'b1;
            end
        end
    end

    assign m0_gnt = grant_vld & ~grant_port;
    assign m1_gnt = grant_vld &  grant_port;

    // Mux the winning requester's fields into the form that gets latched.
    always_comb begin
        req_op = '0;
        if (grant_port) begin
            req_op.port  = 1'b1;
            req_op.we    = m1_we;
            req_op.size  = m1_size;
            req_op.addr  = m1_addr[13:0];
            req_op.wdata = m1_wdata;
            req_op.legal = addr_legal(m1_addr, m1_size);
        end else begin
            req_op.port  = 1'b0;
            req_op.we    = m0_we;
            req_op.size  = m0_size;
            req_op.addr  = m0_addr[13:0];
            req_op.wdata = m0_wdata;
            req_op.legal = addr_legal(m0_addr, m0_size);
        end
    end

    // Next-state logic plus RAM strobes, which are only ever driven in ISSUE.
    always_comb begin
        state_nxt   = state;
        ram_address = '0;
        ram_byteena = '0;
        ram_data    = '0;
        ram_rden    = 1'b0;
        ram_wren    = 1'b0;
        case (op_q.size[1:0])
            2'b00:   be_base = 8'h01;
            2'b01:   be_base = 8'h03;
            2'b10:   be_base = 8'h0F;
            default: be_base = 8'hFF;
        endcase
        case (state)
            S_IDLE: begin
                if (grant_vld) begin
                    state_nxt = req_op.legal ? S_ISSUE : S_RESPOND;
                end
            end
            S_ISSUE: begin
                ram_address = op_q.addr[13:3];
                ram_byteena = be_base << op_q.addr[2:0];
                ram_data    = op_q.wdata << {op_q.addr[2:0], 3'b000};
                ram_wren    = op_q.we;
                ram_rden    = ~op_q.we;
                state_nxt   = op_q.we ? S_RESPOND : S_CAPTURE;
            end
            S_CAPTURE: state_nxt = S_RESPOND;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Align the addressed lane down to bit 0 and sign/zero extend by size.
    always_comb begin
        shifted_q = ram_q >> {op_q.addr[2:0], 3'b000};
        case (op_q.size[1:0])
            2'b00:   load_result = op_q.size[2] ? {{56{shifted_q[7]}},  shifted_q[7:0]}  : {56'h0, shifted_q[7:0]};
            2'b01:   load_result = op_q.size[2] ? {{48{shifted_q[15]}}, shifted_q[15:0]} : {48'h0, shifted_q[15:0]};
            2'b10:   load_result = op_q.size[2] ? {{32{shifted_q[31]}}, shifted_q[31:0]} : {32'h0, shifted_q[31:0]};
            default: load_result = shifted_q;
        endcase
    end

    // Response source: an illegal request goes straight from IDLE, so use the unlatched op there.
    always_comb begin
        resp_port = (state == S_IDLE) ? grant_port    : op_q.port;
        resp_err  = (state == S_IDLE) ? ~req_op.legal : ~op_q.legal;
        resp_data = (state == S_CAPTURE) ? load_result : 64'h0;
    end

    // State register, grant history and latched operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            op_q       <= '0;
        end else begin
            state <= state_nxt;
            if (grant_vld) begin
                last_grant <= grant_port;
                op_q       <= req_op;
            end
        end
    end

    // Registered response: asserted for exactly the RESPOND cycle, zero otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m0_err    <= 1'b0;
            m1_rvalid <= 1'b0;
            m1_rdata  <= '0;
            m1_err    <= 1'b0;
        end else begin
            m0_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m0_err    <= 1'b0;
            m1_rvalid <= 1'b0;
            m1_rdata  <= '0;
            m1_err    <= 1'b0;
            if (state_nxt == S_RESPOND) begin
                if (resp_port) begin
                    m1_rvalid <= 1'b1;
                    m1_rdata  <= resp_data;
                    m1_err    <= resp_err;
                end else begin
                    m0_rvalid <= 1'b1;
                    m0_rdata  <= resp_data;
                    m0_err    <= resp_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Purpose: directed and randomized checks of the data memory arbiter against a byte-level memory model.
// Latency: expected response cycle is derived per request from legality and load/store type.
// Backpressure: requests are held until gnt, then dropped (or held for the round-robin sequence).
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [2:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m1_addr;
    logic [63:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [63:0] m0_rdata, m1_rdata;
    logic [10:0] ram_address;
    logic [7:0]  ram_byteena;
    logic [63:0] ram_data;
    logic        ram_rden, ram_wren;
    logic [63:0] ram_q;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic [7:0]  last_be;
    logic [63:0] ram_w;
    logic [63:0] ram [int];
    logic [7:0]  ref_mem [int];

    always #5 clk = ~clk;

    data_memory_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .ram_address(ram_address), .ram_byteena(ram_byteena), .ram_data(ram_data),
        .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    // RAM with one-cycle registered read and byte-enabled writes.
    always @(posedge clk) begin
        if (ram_rden) begin
            rd_cnt++;
            ram_q <= ram.exists(int'(ram_address)) ? ram[int'(ram_address)] : 64'h0;
        end
        if (ram_wren) begin
            wr_cnt++;
            last_be = ram_byteena;
            ram_w = ram.exists(int'(ram_address)) ? ram[int'(ram_address)] : 64'h0;
            for (int b = 0; b < 8; b++)
                if (ram_byteena[b]) ram_w[8*b +: 8] = ram_data[8*b +: 8];
            ram[int'(ram_address)] = ram_w;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_legal(input logic [31:0] a, input logic [2:0] s);
        int unsigned n = 1 << s[1:0];
        return (a >= 32'h0001_0000) && (a <= 32'h0001_3FFF) && ((a % n) == 0);
    endfunction

    function automatic logic [63:0] model_load(input logic [31:0] a, input logic [2:0] s);
        int unsigned n = 1 << s[1:0];
        logic [63:0] v = 64'h0;
        int idx;
        for (int i = 0; i < int'(n); i++) begin
            idx = int'(a - 32'h0001_0000) + i;
            if (ref_mem.exists(idx)) v = v | (64'(ref_mem[idx]) << (8 * i));
        end
        if (s[2] && n < 8 && v[8*n-1]) v = v | (~64'h0 << (8 * n));
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [2:0] s, input logic [63:0] wd);
        int unsigned n = 1 << s[1:0];
        for (int i = 0; i < int'(n); i++)
            ref_mem[int'(a - 32'h0001_0000) + i] = wd[8*i +: 8];
    endtask

    task automatic drive(input int p, input bit r, input bit we, input logic [2:0] sz,
                         input logic [31:0] a, input logic [63:0] wd);
        if (p == 0) begin
            m0_req = r; m0_we = we; m0_size = sz; m0_addr = a; m0_wdata = wd;
        end else begin
            m1_req = r; m1_we = we; m1_size = sz; m1_addr = a; m1_wdata = wd;
        end
    endtask

    // One complete transaction on one port, checked against the model.
    task automatic run_txn(input int p, input bit we, input logic [2:0] sz, input logic [31:0] a,
                           input logic [63:0] wd, output logic [63:0] got_rdata, output logic got_err);
        bit legal;
        int exp_lat, lat, wr0, rd0;
        bit seen;
        logic [63:0] exp_data;
        legal    = model_legal(a, sz);
        exp_lat  = !legal ? 1 : (we ? 2 : 3);
        exp_data = (legal && !we) ? model_load(a, sz) : 64'h0;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        got_rdata = 64'h0;
        got_err   = 1'b0;
        @(negedge clk);
        drive(p, 1'b1, we, sz, a, wd);
        #1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if ((p == 0) ? m0_gnt : m1_gnt) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check("gnt_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        drive(p, 1'b0, we, sz, a, wd);
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if ((p == 0) ? m0_rvalid : m1_rvalid) begin
                lat       = k;
                got_rdata = (p == 0) ? m0_rdata : m1_rdata;
                got_err   = (p == 0) ? m0_err : m1_err;
                check("other_rvalid", 64'((p == 0) ? m1_rvalid : m0_rvalid), 64'd0);
                break;
            end
        end
        if (legal && we) model_store(a, sz, wd);
        check("latency", 64'(lat), 64'(exp_lat));
        check("rdata", got_rdata, exp_data);
        check("err", 64'(got_err), 64'(!legal));
        check("wr_strobes", 64'(wr_cnt - wr0), 64'(legal && we));
        check("rd_strobes", 64'(rd_cnt - rd0), 64'(legal && !we));
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        bit          seen;
        int          grants, ref_last, p, order;
        bit          both;
        logic [2:0]  sz;
        logic [31:0] a;

        reset_n = 1'b0;
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 64'h0);
        drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 64'h0);
        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err,
                                 ram_rden, ram_wren, ram_byteena, ram_address}), 64'h0);
        check("reset_rdata", m0_rdata | m1_rdata, 64'h0);
        reset_n = 1'b1;

        // Double store then double load.
        run_txn(0, 1'b1, 3'b011, 32'h0001_0008, 64'h1122334455667788, rd, er);
        run_txn(0, 1'b0, 3'b011, 32'h0001_0008, 64'h0, rd, er);
        check("dbl_load_const", rd, 64'h1122334455667788);

        // Byte store at lane 5, signed and unsigned reloads.
        run_txn(0, 1'b1, 3'b000, 32'h0001_0005, 64'h80, rd, er);
        check("byte_be", 64'(last_be), 64'h20);
        run_txn(1, 1'b0, 3'b100, 32'h0001_0005, 64'h0, rd, er);
        check("byte_signed", rd, 64'hFFFF_FFFF_FFFF_FF80);
        run_txn(0, 1'b0, 3'b000, 32'h0001_0005, 64'h0, rd, er);
        check("byte_unsigned", rd, 64'h80);

        // Signed halfwords at the top lane.
        run_txn(1, 1'b1, 3'b001, 32'h0001_0006, 64'h7FFF, rd, er);
        run_txn(0, 1'b0, 3'b101, 32'h0001_0006, 64'h0, rd, er);
        check("half_pos", rd, 64'h7FFF);
        run_txn(0, 1'b1, 3'b001, 32'h0001_0006, 64'h8001, rd, er);
        run_txn(1, 1'b0, 3'b101, 32'h0001_0006, 64'h0, rd, er);
        check("half_neg", rd, 64'hFFFF_FFFF_FFFF_8001);

        // Misaligned and out-of-range requests.
        run_txn(0, 1'b0, 3'b010, 32'h0001_0002, 64'h0, rd, er);
        check("misalign_err", 64'(er), 64'd1);
        run_txn(1, 1'b0, 3'b010, 32'h0002_0000, 64'h0, rd, er);
        check("range_err", 64'(er), 64'd1);

        // Reset while a load is in CAPTURE; a request held during reset must not be granted.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 3'b011, 32'h0001_0008, 64'h0);
        #1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (m0_gnt) begin seen = 1'b1; break; end
            @(negedge clk);
            #1;
        end
        check("rst_gnt_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 3'b011, 32'h0001_0008, 64'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        drive(1, 1'b1, 1'b0, 3'b011, 32'h0001_0000, 64'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("midrst_ctrl", 64'({m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err,
                                      ram_rden, ram_wren, ram_byteena, ram_address}), 64'h0);
            check("midrst_data", m0_rdata | m1_rdata | ram_data, 64'h0);
            @(negedge clk);
        end
        drive(1, 1'b0, 1'b0, 3'b011, 32'h0001_0000, 64'h0);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("postrst_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'h0);
        end

        // Both ports requesting continuously: grants alternate starting at port 0.
        ref_last = 1;
        grants = 0;
        both = 1'b0;
        order = 0;
        drive(0, 1'b1, 1'b0, 3'b010, 32'h0001_0000, 64'h0);
        drive(1, 1'b1, 1'b0, 3'b010, 32'h0001_0008, 64'h0);
        for (int c = 0; c < 60 && grants < 4; c++) begin
            #1;
            if (m0_gnt && m1_gnt) both = 1'b1;
            if (m0_gnt || m1_gnt) begin
                p = m1_gnt ? 1 : 0;
                check("rr_turn", 64'(p), 64'(1 - ref_last));
                order = order | (p << grants);
                ref_last = p;
                grants++;
            end
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, 3'b010, 32'h0001_0000, 64'h0);
        drive(1, 1'b0, 1'b0, 3'b010, 32'h0001_0008, 64'h0);
        repeat (6) @(negedge clk);
        check("rr_count", 64'(grants), 64'd4);
        check("rr_order", 64'(order), 64'b1010);
        check("rr_never_both", 64'(both), 64'd0);

        // Randomized mix including window edges and misalignment.
        for (int i = 0; i < 40; i++) begin
            sz = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       a = 32'h0001_3FF8 + $urandom_range(0, 15);
                1:       a = 32'h0000_FFF8 + $urandom_range(0, 15);
                default: a = 32'h0001_0000 + $urandom_range(0, 63);
            endcase
            if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << sz[1:0]) - 32'd1);
            run_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, a,
                    {$urandom, $urandom}, rd, er);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
